// File: rtl/maze_solver_arb.sv
// maze_solver_arb: two-client round-robin arbiter in front of one shared maze-solver core.
// Forwards the granted client's serial maze to the solver and routes the result burst back.
// Optional feature: define MAZE_ARB_TIMEOUT_EN to abort a job when the solver stays silent in WAIT.
module maze_solver_arb #(
  parameter int unsigned MAZE_BITS   = 225,
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cl_req,
  output logic [1:0]           cl_gnt,
  input  logic [1:0]           cl_in_valid,
  input  logic [1:0]           cl_maze,
  output logic [1:0]           cl_out_valid,
  output logic [1:0]           cl_maze_not_valid,
  output logic [2*COORD_W-1:0] cl_out_x,
  output logic [2*COORD_W-1:0] cl_out_y,
  output logic                 s_in_valid,
  output logic                 s_maze,
  input  logic                 s_out_valid,
  input  logic                 s_maze_not_valid,
  input  logic [COORD_W-1:0]   s_out_x,
  input  logic [COORD_W-1:0]   s_out_y,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = $clog2(MAZE_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_gnt;
  logic             gsel;
  logic             pick_c;

`ifdef MAZE_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] wait_cnt;
`else
  // Keeps the timeout parameter referenced when the abort path is compiled out.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  function automatic logic [1:0] one_hot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2*COORD_W-1:0] place(input logic sel, input logic [COORD_W-1:0] v);
    return sel ? {v, {COORD_W{1'b0}}} : {{COORD_W{1'b0}}, v};
  endfunction

  // Round-robin choice: a lone requester wins; on a tie the client not granted last wins.
  assign pick_c = (cl_req == 2'b11) ? ~last_gnt : cl_req[1];

  // Arbitration FSM with registered solver-side and client-side forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      last_gnt          <= 1'b1;
      gsel              <= 1'b0;
      cl_gnt            <= 2'b00;
      cl_out_valid      <= 2'b00;
      cl_maze_not_valid <= 2'b00;
      cl_out_x          <= '0;
      cl_out_y          <= '0;
      s_in_valid        <= 1'b0;
      s_maze            <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
`ifdef MAZE_ARB_TIMEOUT_EN
      wait_cnt          <= '0;
`endif
    end else begin
      s_in_valid        <= 1'b0;
      s_maze            <= 1'b0;
      cl_out_valid      <= 2'b00;
      cl_maze_not_valid <= 2'b00;
      cl_out_x          <= '0;
      cl_out_y          <= '0;
      timeout_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (|cl_req) begin
            gsel     <= pick_c;
            last_gnt <= pick_c;
            cl_gnt   <= one_hot(pick_c);
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          s_in_valid <= cl_in_valid[gsel];
          s_maze     <= cl_maze[gsel];
          if (cl_in_valid[gsel]) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(MAZE_BITS - 1)) begin
              state <= WAIT;
`ifdef MAZE_ARB_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (s_out_valid) begin
            cl_out_valid      <= one_hot(gsel);
            cl_maze_not_valid <= s_maze_not_valid ? one_hot(gsel) : 2'b00;
            cl_out_x          <= place(gsel, s_out_x);
            cl_out_y          <= place(gsel, s_out_y);
            state             <= STREAM;
          end
`ifdef MAZE_ARB_TIMEOUT_EN
          else if (wait_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            timeout_err       <= 1'b1;
            cl_out_valid      <= one_hot(gsel);
            cl_maze_not_valid <= one_hot(gsel);
            cl_gnt            <= 2'b00;
            state             <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        STREAM: begin
          cl_out_valid      <= s_out_valid ? one_hot(gsel) : 2'b00;
          cl_maze_not_valid <= s_maze_not_valid ? one_hot(gsel) : 2'b00;
          cl_out_x          <= s_out_valid ? place(gsel, s_out_x) : '0;
          cl_out_y          <= s_out_valid ? place(gsel, s_out_y) : '0;
          if (!s_out_valid) begin
            cl_gnt <= 2'b00;
            state  <= DONE;
          end
        end
        DONE: begin
          cl_gnt  <= 2'b00;
          bit_cnt <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          cl_gnt <= 2'b00;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_solver_arb.sv
// tb_maze_solver_arb: table-driven and randomized jobs checked against a transaction-level model
// of the arbiter (round-robin pick, 225-bit job length, one-cycle forwarding on both sides).
module tb_maze_solver_arb;

  localparam int unsigned MAZE_BITS   = 225;
  localparam int unsigned COORD_W     = 4;
  localparam int unsigned TIMEOUT_CYC = 1000;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           cl_req;
  logic [1:0]           cl_gnt;
  logic [1:0]           cl_in_valid;
  logic [1:0]           cl_maze;
  logic [1:0]           cl_out_valid;
  logic [1:0]           cl_maze_not_valid;
  logic [2*COORD_W-1:0] cl_out_x;
  logic [2*COORD_W-1:0] cl_out_y;
  logic                 s_in_valid;
  logic                 s_maze;
  logic                 s_out_valid;
  logic                 s_maze_not_valid;
  logic [COORD_W-1:0]   s_out_x;
  logic [COORD_W-1:0]   s_out_y;
  logic                 busy;
  logic                 timeout_err;

  maze_solver_arb #(
    .MAZE_BITS  (MAZE_BITS),
    .COORD_W    (COORD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cl_req           (cl_req),
    .cl_gnt           (cl_gnt),
    .cl_in_valid      (cl_in_valid),
    .cl_maze          (cl_maze),
    .cl_out_valid     (cl_out_valid),
    .cl_maze_not_valid(cl_maze_not_valid),
    .cl_out_x         (cl_out_x),
    .cl_out_y         (cl_out_y),
    .s_in_valid       (s_in_valid),
    .s_maze           (s_maze),
    .s_out_valid      (s_out_valid),
    .s_maze_not_valid (s_maze_not_valid),
    .s_out_x          (s_out_x),
    .s_out_y          (s_out_y),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int model_last = 1;

  typedef struct {
    logic [1:0] req;
    int         exp_g;
    int         gap_at;
    int         gap_len;
    int         extra;
    int         delay;
    int         npairs;
    bit         invalid;
    bit         drop;
  } job_t;

  job_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] pl(input int g, input logic [3:0] v);
    return (g == 1) ? {v, 4'h0} : {4'h0, v};
  endfunction

  // Reference arbitration rule: lone requester wins, tie goes to the client not granted last.
  function automatic int rr_pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(cl_gnt), 32'd0);
    chk({tag, "_ov"},   32'(cl_out_valid), 32'd0);
    chk({tag, "_nv"},   32'(cl_maze_not_valid), 32'd0);
    chk({tag, "_x"},    32'(cl_out_x), 32'd0);
    chk({tag, "_y"},    32'(cl_out_y), 32'd0);
    chk({tag, "_siv"},  32'(s_in_valid), 32'd0);
    chk({tag, "_sm"},   32'(s_maze), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tmo"},  32'(timeout_err), 32'd0);
  endtask

  task automatic do_grant(input logic [1:0] req, input int exp_g);
    int n = 0;
    cl_req = req;
    do begin
      @(negedge clk);
      n++;
    end while (cl_gnt == 2'b00 && n < 8);
    chk("grant", 32'(cl_gnt), 32'(oh(exp_g)));
    chk("grant_latency", 32'(n), 32'd1);
    chk("busy_on_grant", 32'(busy), 32'd1);
    model_last = exp_g;
  endtask

  task automatic do_load(input int g, input int gap_at, input int gap_len, input int extra, input bit drop);
    int   sent     = 0;
    int   gap_left = gap_len;
    int   nfwd     = 0;
    bit   pv       = 1'b0;
    bit   pb       = 1'b0;
    bit   v;
    bit   b;
    logic gi;
    logic go;
    gi = 1'(g);
    go = ~gi;
    for (int c = 0; c <= int'(MAZE_BITS) + extra + gap_len; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("s_in_valid", 32'(s_in_valid), 32'(pv));
        if (pv) chk("s_maze", 32'(s_maze), 32'(pb));
        if (s_in_valid) nfwd++;
      end
      chk("gnt_load", 32'(cl_gnt), 32'(oh(g)));
      v = 1'b0;
      b = 1'($urandom);
      if (sent < int'(MAZE_BITS) + extra) begin
        if (sent == gap_at && gap_left > 0) gap_left--;
        else begin
          v = 1'b1;
          sent++;
        end
      end
      pv = v && (sent <= int'(MAZE_BITS));
      pb = b;
      cl_in_valid[gi] = v;
      cl_maze[gi]     = b;
      cl_in_valid[go] = 1'($urandom);
      cl_maze[go]     = 1'($urandom);
      if (drop && sent >= 50) cl_req[gi] = 1'b0;
    end
    @(negedge clk);
    chk("s_in_valid_tail", 32'(s_in_valid), 32'(pv));
    if (s_in_valid) nfwd++;
    cl_in_valid = 2'b00;
    cl_maze     = 2'b00;
    chk("fwd_count", 32'(nfwd), 32'(MAZE_BITS));
  endtask

  task automatic do_result(input int g, input int delay, input int npairs, input bit invalid);
    bit         pv = 1'b0;
    bit         pn = 1'b0;
    logic [3:0] px = 4'h0;
    logic [3:0] py = 4'h0;
    for (int c = 0; c <= delay + npairs; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("out_valid", 32'(cl_out_valid), 32'(pv ? oh(g) : 2'b00));
        chk("not_valid", 32'(cl_maze_not_valid), 32'(pn ? oh(g) : 2'b00));
        chk("out_x", 32'(cl_out_x), 32'(pv ? pl(g, px) : 8'h00));
        chk("out_y", 32'(cl_out_y), 32'(pv ? pl(g, py) : 8'h00));
      end
      chk("gnt_hold", 32'(cl_gnt), 32'(oh(g)));
      chk("timeout_err_low", 32'(timeout_err), 32'd0);
      if (c >= delay && c < delay + npairs) begin
        pv = 1'b1;
        pn = invalid;
        if (invalid) begin
          px = 4'h0;
          py = 4'h0;
        end else if (c == delay + npairs - 1) begin
          px = 4'd14;
          py = 4'd14;
        end else begin
          px = 4'($urandom);
          py = 4'($urandom);
        end
      end else begin
        pv = 1'b0;
        pn = 1'b0;
        px = 4'($urandom);
        py = 4'($urandom);
      end
      s_out_valid      = pv;
      s_maze_not_valid = pn;
      s_out_x          = px;
      s_out_y          = py;
    end
    @(negedge clk);
    chk("out_valid_end", 32'(cl_out_valid), 32'd0);
    chk("out_x_end", 32'(cl_out_x), 32'd0);
    chk("gnt_clear_done", 32'(cl_gnt), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    s_out_x = 4'h0;
    s_out_y = 4'h0;
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("gnt_idle", 32'(cl_gnt), 32'd0);
  endtask

  task automatic run_job(input job_t j);
    do_grant(j.req, j.exp_g);
    do_load(j.exp_g, j.gap_at, j.gap_len, j.extra, j.drop);
    do_result(j.exp_g, j.delay, j.npairs, j.invalid);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int   g;
    int   seen;
    int   k;
    job_t rj;

    //          req    g  gap_at gap_len extra delay npairs inv drop
    tbl[0] = '{2'b11, 0, 0,   0, 0, 2, 3, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 1, 0,   0, 0, 1, 2, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 0, 0,   0, 0, 0, 4, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 1, 0,   0, 0, 3, 1, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 0, 0,   0, 0, 3, 5, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 1, 0,   0, 0, 2, 1, 1'b1, 1'b0};
    tbl[6] = '{2'b10, 1, 100, 3, 2, 1, 3, 1'b0, 1'b0};
    tbl[7] = '{2'b01, 0, 60,  2, 1, 2, 2, 1'b0, 1'b1};

    rst_n            = 1'b0;
    cl_req           = 2'b00;
    cl_in_valid      = 2'b00;
    cl_maze          = 2'b00;
    s_out_valid      = 1'b0;
    s_maze_not_valid = 1'b0;
    s_out_x          = 4'h0;
    s_out_y          = 4'h0;

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_req_gnt", 32'(cl_gnt), 32'd0);
    chk("no_req_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Asynchronous reset in the middle of a load.
    g = rr_pick(2'b01, model_last);
    do_grant(2'b01, g);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      cl_in_valid = 2'b01;
      cl_maze     = 2'(c & 1);
    end
    @(negedge clk);
    chk("pre_reset_siv", 32'(s_in_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n       = 1'b1;
    cl_in_valid = 2'b00;
    cl_maze     = 2'b00;
    cl_req      = 2'b00;
    model_last  = 1;
    repeat (3) @(negedge clk);
    chk("post_reset_gnt", 32'(cl_gnt), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Silent solver: abort with the option, indefinite wait without it.
    g = rr_pick(2'b11, model_last);
    do_grant(2'b11, g);
    do_load(g, 0, 0, 0, 1'b0);
`ifdef MAZE_ARB_TIMEOUT_EN
    k = 0;
    while (cl_out_valid == 2'b00 && k < 1100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_wait_cycles", 32'(k + 1), 32'(TIMEOUT_CYC));
    chk("timeout_err_pulse", 32'(timeout_err), 32'd1);
    chk("timeout_ov", 32'(cl_out_valid), 32'(oh(g)));
    chk("timeout_nv", 32'(cl_maze_not_valid), 32'(oh(g)));
    chk("timeout_x", 32'(cl_out_x), 32'd0);
    chk("timeout_y", 32'(cl_out_y), 32'd0);
    @(negedge clk);
    chk("timeout_err_once", 32'(timeout_err), 32'd0);
    chk("timeout_ov_once", 32'(cl_out_valid), 32'd0);
    chk("timeout_idle", 32'(busy), 32'd0);
    g = rr_pick(2'b11, model_last);
    do_grant(2'b11, g);
    do_load(g, 0, 0, 0, 1'b0);
    do_result(g, 1, 2, 1'b0);
`else
    seen = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (cl_out_valid != 2'b00 || timeout_err) seen++;
    end
    chk("wait_indefinite", 32'(seen), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_gnt", 32'(cl_gnt), 32'(oh(g)));
    do_result(g, 2, 3, 1'b0);
`endif

    // Randomized jobs; expected grant comes from the round-robin model.
    for (int i = 0; i < 8; i++) begin
      rj.req     = 2'($urandom_range(1, 3));
      rj.exp_g   = rr_pick(rj.req, model_last);
      rj.gap_at  = int'($urandom_range(1, 224));
      rj.gap_len = int'($urandom_range(0, 4));
      rj.extra   = int'($urandom_range(0, 3));
      rj.delay   = int'($urandom_range(0, 4));
      rj.invalid = ($urandom_range(0, 3) == 0);
      rj.npairs  = rj.invalid ? 1 : int'($urandom_range(1, 6));
      rj.drop    = 1'($urandom);
      run_job(rj);
    end

    cl_req = 2'b00;
    repeat (2) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_solver_arb.md
Name: maze_solver_arb

Overview:
- Two-client round-robin arbiter in front of one shared maze-solver core.
- Grants the solver to one client at a time and forwards that client's serial 225-bit maze stream (in_valid/maze) to the solver.
- Routes the solver's path result (out_valid, maze_not_valid, out_x, out_y) back to the granted client only.
- Holds the grant until the solver's result burst ends.

Parameters:
- MAZE_BITS, 225, maze bits per job (15x15, row-major serial).
- COORD_W, 4, width of out_x/out_y.
- TIMEOUT_CYC, 1000, max idle cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cl_req  in  2  per-client request; held high until that client's result burst ends.
- cl_gnt  out  2  one-hot grant.
- cl_in_valid  in  2  per-client maze bit valid.
- cl_maze  in  2  per-client maze bit.
- cl_out_valid  out  2  per-client result valid.
- cl_maze_not_valid  out  2  per-client "no path" flag.
- cl_out_x  out  2*COORD_W  packed path x; client i uses bits [i*COORD_W +: COORD_W].
- cl_out_y  out  2*COORD_W  packed path y, same packing as cl_out_x.
- s_in_valid  out  1  to solver in_valid.
- s_maze  out  1  to solver maze bit.
- s_out_valid  in  1  from solver.
- s_maze_not_valid  in  1  from solver.
- s_out_x  in  COORD_W  from solver.
- s_out_y  in  COORD_W  from solver.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle abort pulse.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; bit counter=0; last-grant pointer=1, so client 0 wins the first tie.
- Registered outputs: every output is registered. Solver-side and client-side forwarding each add exactly 1 cycle of latency.
- FSM states: IDLE, LOAD, WAIT, STREAM, DONE.
- IDLE:
  - If any cl_req is high, pick a client g and go to LOAD; cl_gnt[g] rises the next cycle.
  - One requester: pick it.
  - Both requesting: pick the client that is not the last-granted one. Update the pointer on every grant.
- LOAD:
  - s_in_valid and s_maze follow cl_in_valid[g] and cl_maze[g] with a 1-cycle delay.
  - Gap cycles (cl_in_valid[g]=0) are forwarded as-is and are not counted.
  - The other client's inputs are ignored.
  - The counter increments on each valid bit. When the MAZE_BITS-th bit is accepted, go to WAIT.
  - Valid bits from g beyond MAZE_BITS are dropped; they are never forwarded.
- WAIT: on s_out_valid=1, go to STREAM. The same cycle's result is captured and forwarded.
- STREAM:
  - Each cycle, cl_out_valid[g], cl_maze_not_valid[g] and cl_out_x/y slice g equal the solver values from the previous cycle.
  - The non-granted client's outputs stay 0.
  - out_x/out_y slices are forced to 0 whenever the matching cl_out_valid is 0.
  - When s_out_valid falls, go to DONE.
- DONE:
  - cl_gnt is cleared and the counter is reset to 0.
  - Go to IDLE next cycle.
  - A cl_req still high in IDLE counts as a new request.
- cl_gnt stays high from LOAD through STREAM inclusive.
- cl_req dropped mid-job: ignored. The job completes; arbitration is non-preemptive.
- Simultaneous requests on the DONE->IDLE boundary: resolved by the pointer, so a waiting client is guaranteed the next grant.
- Asynchronous reset mid-job: immediate return to reset values; s_in_valid drops without completing the maze.

Optional Feature:
- Macro: MAZE_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC with no s_out_valid, pulse timeout_err for 1 cycle.
  - In that same abort, drive cl_out_valid[g]=1 and cl_maze_not_valid[g]=1 for exactly 1 cycle (x/y=0), then go to DONE.
- Undefined: WAIT waits indefinitely; timeout_err is tied to 0; no counter logic is present.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 within the same cycle. After release, no grant without a request.
- Single job:
  - Stimulus: client 0 req; 225 valid bits; solver then returns 5 (x,y) pairs ending at (14,14).
  - Required: cl_gnt=01; s_maze equals the client bits delayed by 1 cycle; s_in_valid high for exactly 225 cycles.
  - Required: client 0 sees 5 valid cycles with identical pairs, 1 cycle late; client 1 outputs stay 0 throughout.
- Round-robin: both clients hold req continuously -> grants alternate 01, 10, 01, 10 across four jobs. The first grant goes to client 0.
- Invalid maze: solver returns out_valid=1 with maze_not_valid=1 for 1 cycle -> granted client sees out_valid=1, maze_not_valid=1, x=y=0 for 1 cycle; FSM reaches IDLE 2 cycles later.
- Gapped input and overrun:
  - Stimulus: client 1 sends 100 bits, a 3-cycle gap, 125 bits, then 2 extra bits.
  - Required: LOAD exits after the 225th valid bit; the 2 extra bits are never forwarded.
- Timeout (with MAZE_ARB_TIMEOUT_EN): the solver never responds -> after 1000 WAIT cycles, timeout_err pulses once; the client sees a 1-cycle not-valid result; the next requester is granted.
